// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings and helpers for the write-back stage.
package wb_pkg;

   localparam logic [1:0] WOS_SET  = 2'b00;
   localparam logic [1:0] WOS_EXT  = 2'b01;
   localparam logic [1:0] WOS_PC4  = 2'b10;
   localparam logic [1:0] WOS_NONE = 2'b11;

   localparam logic [1:0] WHB_B = 2'b00;
   localparam logic [1:0] WHB_H = 2'b01;
   localparam logic [1:0] WHB_W = 2'b10;
   localparam logic [1:0] WHB_D = 2'b11;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

   // A dword request on a 32-bit datapath degrades to a word access.
   function automatic logic [1:0] eff_whb(input logic [1:0] whb, input int xlen);
      logic [1:0] r;
      r = whb;
      if ((xlen == 32) && (whb == WHB_D)) begin
         r = WHB_W;
      end else begin
         r = whb;
      end
      return r;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] whb, input logic [2:0] lo);
      logic r;
      case (whb)
         WHB_B:   r = 1'b0;
         WHB_H:   r = lo[0];
         WHB_W:   r = (lo[1:0] != 2'b00);
         WHB_D:   r = (lo != 3'b000);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Byte-lane select plus sign/zero extension, shared by load data and ALU results.
module load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      lane_i,
   input  logic [1:0]      whb_i,
   input  logic            su_i,
   output logic [XLEN-1:0] data_o
);

   logic [5:0]      shamt_s;
   logic [XLEN-1:0] shifted_s;
   logic [XLEN-1:0] mask_s;
   logic [6:0]      width_s;
   logic            sign_s;

   // Shift the addressed lane down, then mask to the access size and extend.
   always_comb begin
      shamt_s = 6'd0;
      if (XLEN == 64) begin
         shamt_s = {lane_i, 3'b000};
      end else begin
         shamt_s = {1'b0, lane_i[1:0], 3'b000};
      end
      shifted_s = data_i >> shamt_s;
      width_s   = 7'd8;
      sign_s    = 1'b0;
      case (whb_i)
         WHB_B: begin
            width_s = 7'd8;
            sign_s  = shifted_s[7];
         end
         WHB_H: begin
            width_s = 7'd16;
            sign_s  = shifted_s[15];
         end
         WHB_W: begin
            width_s = 7'd32;
            sign_s  = shifted_s[31];
         end
         WHB_D: begin
            width_s = 7'(XLEN);
            sign_s  = shifted_s[XLEN-1];
         end
         default: begin
            width_s = 7'd8;
            sign_s  = 1'b0;
         end
      endcase
      mask_s = ~({XLEN{1'b1}} << width_s);
      if (sign_s && !su_i) begin
         data_o = (shifted_s & mask_s) | ~mask_s;
      end else begin
         data_o = shifted_s & mask_s;
      end
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: source select, load alignment, regfile write port.
// Optional macro WB_BYPASS_EN exposes the next-cycle write for EX forwarding.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [REG_AW-1:0]   in_rd,
   input  logic                in_is_load,
   input  logic [1:0]          in_wos,
   input  logic [1:0]          in_whb,
   input  logic                in_su,
   input  logic [2:0]          in_addr_lo,
   input  logic [XLEN-1:0]     in_result,
   input  logic [XLEN-1:0]     in_pc4,
   input  logic                in_lt,
   input  logic                in_ltu,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic                misalign,
   output logic                stray_rsp,
   output logic [RETIRE_W-1:0] retire_cnt
`ifdef WB_BYPASS_EN
   ,
   output logic                byp_valid,
   output logic [REG_AW-1:0]   byp_rd,
   output logic [XLEN-1:0]     byp_data
`endif
);

   wb_state_e state_q, state_d;

   logic [REG_AW-1:0]   rd_q, rd_d;
   logic [1:0]          whb_q, whb_d;
   logic                su_q, su_d;
   logic [2:0]          addr_lo_q, addr_lo_d;
   logic [1:0]          wos_q, wos_d;

   logic                rf_we_q;
   logic [REG_AW-1:0]   rf_waddr_q;
   logic [XLEN-1:0]     rf_wdata_q;
   logic                misalign_q;
   logic                stray_q;
   logic [RETIRE_W-1:0] retire_q;

   logic                wr_fire_s;
   logic [REG_AW-1:0]   wr_rd_s;
   logic [1:0]          wr_wos_s;
   logic                wr_mis_s;
   logic                wr_we_s;
   logic [XLEN-1:0]     wr_data_s;
   logic                stray_s;

   logic [XLEN-1:0]     al_data_s;
   logic [2:0]          al_lane_s;
   logic [1:0]          al_whb_s;
   logic                al_su_s;
   logic [XLEN-1:0]     al_out_s;

   load_align #(.XLEN(XLEN)) u_align (
      .data_i (al_data_s),
      .lane_i (al_lane_s),
      .whb_i  (al_whb_s),
      .su_i   (al_su_s),
      .data_o (al_out_s)
   );

   // Next state, load-context capture and the write decision for this cycle.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      whb_d     = whb_q;
      su_d      = su_q;
      addr_lo_d = addr_lo_q;
      wos_d     = wos_q;
      wr_fire_s = 1'b0;
      wr_rd_s   = in_rd;
      wr_wos_s  = in_wos;
      wr_mis_s  = 1'b0;
      stray_s   = 1'b0;
      al_data_s = in_result;
      al_lane_s = 3'b000;
      al_whb_s  = eff_whb(in_whb, XLEN);
      al_su_s   = in_su;
      case (state_q)
         IDLE: begin
            // A response here (even alongside a load transfer) is never consumed.
            stray_s = mem_rvalid;
            if (in_valid && in_is_load) begin
               rd_d      = in_rd;
               whb_d     = eff_whb(in_whb, XLEN);
               su_d      = in_su;
               addr_lo_d = in_addr_lo;
               wos_d     = in_wos;
               state_d   = WAIT_MEM;
            end else if (in_valid) begin
               wr_fire_s = 1'b1;
               wr_mis_s  = (in_wos == WOS_EXT) && is_misaligned(al_whb_s, in_addr_lo);
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_MEM: begin
            wr_rd_s   = rd_q;
            wr_wos_s  = wos_q;
            al_data_s = mem_rdata;
            al_lane_s = addr_lo_q;
            al_whb_s  = whb_q;
            al_su_s   = su_q;
            wr_mis_s  = is_misaligned(whb_q, addr_lo_q);
            if (mem_rvalid) begin
               wr_fire_s = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = WAIT_MEM;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Write-data source select; loads always write the aligned response.
   always_comb begin
      wr_data_s = al_out_s;
      if (state_q == WAIT_MEM) begin
         wr_data_s = al_out_s;
      end else begin
         case (in_wos)
            WOS_SET:  wr_data_s = {{(XLEN-1){1'b0}}, (in_lt | in_ltu)};
            WOS_EXT:  wr_data_s = al_out_s;
            WOS_PC4:  wr_data_s = in_pc4;
            WOS_NONE: wr_data_s = {XLEN{1'b0}};
            default:  wr_data_s = {XLEN{1'b0}};
         endcase
      end
   end

   assign wr_we_s = wr_fire_s && (wr_rd_s != {REG_AW{1'b0}}) &&
                    (wr_wos_s != WOS_NONE) && !wr_mis_s;

   // State, captured load context and registered regfile port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_q       <= {REG_AW{1'b0}};
         whb_q      <= WHB_B;
         su_q       <= 1'b0;
         addr_lo_q  <= 3'b000;
         wos_q      <= WOS_SET;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= {REG_AW{1'b0}};
         rf_wdata_q <= {XLEN{1'b0}};
         misalign_q <= 1'b0;
         stray_q    <= 1'b0;
         retire_q   <= {RETIRE_W{1'b0}};
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         whb_q      <= whb_d;
         su_q       <= su_d;
         addr_lo_q  <= addr_lo_d;
         wos_q      <= wos_d;
         rf_we_q    <= wr_we_s;
         misalign_q <= wr_fire_s && wr_mis_s;
         stray_q    <= stray_s;
         if (wr_fire_s) begin
            rf_waddr_q <= wr_rd_s;
            rf_wdata_q <= wr_data_s;
            retire_q   <= retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign misalign   = misalign_q;
   assign stray_rsp  = stray_q;
   assign retire_cnt = retire_q;

`ifdef WB_BYPASS_EN
   assign byp_valid = wr_we_s;
   assign byp_rd    = wr_rd_s;
   assign byp_data  = wr_data_s;
`endif

endmodule
